// File: rtl/gon_pkg.sv
// gon_pkg: array geometry, pointer widths and output beat type shared by the
// gather network.
package gon_pkg;
    localparam int GON_DATA_WIDTH    = 64;
    localparam int GON_ROW_TAG_WIDTH = 4;
    localparam int GON_COL_TAG_WIDTH = 4;
    localparam int GON_NUM_OF_ROWS   = 12;
    localparam int GON_NUM_OF_COLS   = 14;
    localparam int ROW_PTR_W = $clog2(GON_NUM_OF_ROWS);
    localparam int COL_PTR_W = $clog2(GON_NUM_OF_COLS);

    typedef struct packed {
        logic [GON_DATA_WIDTH-1:0]    data;
        logic [GON_ROW_TAG_WIDTH-1:0] row_tag;
        logic [GON_COL_TAG_WIDTH-1:0] col_tag;
    } beat_t;
endpackage

// File: rtl/gon_rr_arb.sv
// gon_rr_arb: combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (all-zero when nothing requests)
//   gnt_idx : index of the granted requester
//   any     : at least one request present
module gon_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int W = $clog2(N);

    logic [W:0] s;

    // Scan priority offsets from the far end back toward ptr so the
    // closest requester is the last one written.
    always_comb begin
        gnt_idx = '0;
        any = 1'b0;
        s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (W+1)'(i);
            if (s >= (W+1)'(N)) s = s - (W+1)'(N);
            if (req[s[W-1:0]]) begin
                any = 1'b1;
                gnt_idx = s[W-1:0];
            end
        end
        gnt = '0;
        gnt[gnt_idx] = any;
    end
endmodule

// File: rtl/gon_gather.sv
// gon_gather: collects PE result words into one registered output stream.
//   clk, reset (async, active-low)
//   row_id/col_id : configured tags per row / per PE
//   data_in, valid_in, ready_out : PE side handshake (ready_out is the grant)
//   enable_in : 0 blocks new grants
//   data_out, row_tag_out, col_tag_out, valid_out, ready_in : buffer side
module gon_gather
    import gon_pkg::*;
#(
    parameter int DATA_WIDTH    = GON_DATA_WIDTH,
    parameter int ROW_TAG_WIDTH = GON_ROW_TAG_WIDTH,
    parameter int COL_TAG_WIDTH = GON_COL_TAG_WIDTH,
    parameter int NUM_OF_ROWS   = GON_NUM_OF_ROWS,
    parameter int NUM_OF_COLS   = GON_NUM_OF_COLS
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic [NUM_OF_ROWS-1:0][ROW_TAG_WIDTH-1:0]                row_id,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] col_id,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                  valid_in,
    output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                  ready_out,
    input  logic                                                     enable_in,
    output logic [DATA_WIDTH-1:0]                                    data_out,
    output logic [ROW_TAG_WIDTH-1:0]                                 row_tag_out,
    output logic [COL_TAG_WIDTH-1:0]                                 col_tag_out,
    output logic                                                     valid_out,
    input  logic                                                     ready_in
);
    logic [NUM_OF_ROWS-1:0]                 row_req;
    logic [NUM_OF_ROWS-1:0]                 row_gnt;
    logic [ROW_PTR_W-1:0]                   row_idx;
    logic                                   row_any;
    logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] col_gnt;
    logic [NUM_OF_ROWS-1:0][COL_PTR_W-1:0]  col_idx;
    logic [NUM_OF_ROWS-1:0]                 col_any;
    logic [COL_PTR_W-1:0]                   col_w;
    logic                                   load_ok;
    logic                                   xfer;
    logic [ROW_PTR_W-1:0]                   rp_q, rp_d;
    logic [NUM_OF_ROWS-1:0][COL_PTR_W-1:0]  cp_q, cp_d;
    logic                                   valid_q, valid_d;
    beat_t                                  beat_q, beat_d;

    gon_rr_arb #(.N(NUM_OF_ROWS)) u_row_arb (
        .req    (row_req),
        .ptr    (rp_q),
        .gnt    (row_gnt),
        .gnt_idx(row_idx),
        .any    (row_any)
    );

    genvar r;
    generate
        for (r = 0; r < NUM_OF_ROWS; r++) begin : g_row
            assign row_req[r] = |valid_in[r];
            gon_rr_arb #(.N(NUM_OF_COLS)) u_col_arb (
                .req    (valid_in[r]),
                .ptr    (cp_q[r]),
                .gnt    (col_gnt[r]),
                .gnt_idx(col_idx[r]),
                .any    (col_any[r])
            );
        end
    endgenerate

    assign col_w   = col_idx[row_idx];
    assign load_ok = enable_in && (!valid_q || ready_in);
    // Gated by reset so no PE is granted while the block is held in reset.
    assign xfer    = reset && load_ok && row_any && col_any[row_idx];

    always_comb begin
        for (int i = 0; i < NUM_OF_ROWS; i++)
            ready_out[i] = (xfer && row_gnt[i]) ? col_gnt[i] : '0;
    end

    always_comb begin
        rp_d = rp_q;
        cp_d = cp_q;
        beat_d = beat_q;
        valid_d = valid_q && !ready_in;
        if (xfer) begin
            rp_d = (row_idx == ROW_PTR_W'(NUM_OF_ROWS - 1)) ? '0 : row_idx + 1'b1;
            cp_d[row_idx] = (col_w == COL_PTR_W'(NUM_OF_COLS - 1)) ? '0 : col_w + 1'b1;
            beat_d.data = data_in[row_idx][col_w];
            beat_d.row_tag = row_id[row_idx];
            beat_d.col_tag = col_id[row_idx][col_w];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp_q <= '0;
            cp_q <= '0;
            valid_q <= 1'b0;
            beat_q <= '0;
        end else begin
            rp_q <= rp_d;
            cp_q <= cp_d;
            valid_q <= valid_d;
            beat_q <= beat_d;
        end
    end

    assign data_out    = beat_q.data;
    assign row_tag_out = beat_q.row_tag;
    assign col_tag_out = beat_q.col_tag;
    assign valid_out   = valid_q;
endmodule

// File: tb/tb_gon_gather.sv
// tb_gon_gather: directed sequence with random traffic against a grant model.
module tb_gon_gather;
    localparam int R = 12, C = 14, DW = 64, RW = 4, CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [R-1:0][RW-1:0]         row_id;
    logic [R-1:0][C-1:0][CW-1:0]  col_id;
    logic [R-1:0][C-1:0][DW-1:0]  data_in;
    logic [R-1:0][C-1:0]          valid_in;
    logic [R-1:0][C-1:0]          ready_out;
    logic                         enable_in, ready_in, valid_out;
    logic [DW-1:0]                data_out;
    logic [RW-1:0]                row_tag_out;
    logic [CW-1:0]                col_tag_out;

    int total = 0, bad = 0;
    int mrp;
    int mcp[R];
    bit mv;
    logic [DW-1:0] md;
    logic [RW-1:0] mrt;
    logic [CW-1:0] mct;
    int gcnt[R][C];

    gon_gather dut (
        .clk(clk), .reset(reset), .row_id(row_id), .col_id(col_id),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .enable_in(enable_in), .data_out(data_out), .row_tag_out(row_tag_out),
        .col_tag_out(col_tag_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_ro(input string tag, input logic [R-1:0][C-1:0] exp);
        total++;
        assert (ready_out === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, ready_out, exp);
        end
    endtask

    task automatic model_reset();
        mrp = 0;
        for (int r = 0; r < R; r++) mcp[r] = 0;
        mv = 0; md = '0; mrt = '0; mct = '0;
    endtask

    // Round-robin rules: first requesting row from mrp, then first valid column from mcp[row].
    function automatic void pick(output bit f, output int wr, output int wc);
        f = 0; wr = 0; wc = 0;
        for (int i = 0; i < R && !f; i++) begin
            int rr;
            rr = (mrp + i) % R;
            if (valid_in[rr] != '0) begin
                f = 1; wr = rr;
                for (int j = C - 1; j >= 0; j--)
                    if (valid_in[rr][(mcp[rr] + j) % C]) wc = (mcp[rr] + j) % C;
            end
        end
    endfunction

    task automatic step();
        bit f, x;
        int wr, wc;
        logic [R-1:0][C-1:0] exp_ro;
        #1;
        pick(f, wr, wc);
        x = f && enable_in && (!mv || ready_in);
        exp_ro = '0;
        if (x) exp_ro[wr][wc] = 1'b1;
        chk_ro("ready_out", exp_ro);
        if (x) begin
            md = data_in[wr][wc]; mrt = row_id[wr]; mct = col_id[wr][wc]; mv = 1;
            mrp = (wr + 1) % R; mcp[wr] = (wc + 1) % C; gcnt[wr][wc]++;
        end else if (mv && ready_in) mv = 0;
        @(posedge clk);
        #1;
        chk("valid_out", 64'(valid_out), 64'(mv));
        chk("data_out", data_out, md);
        chk("row_tag", 64'(row_tag_out), 64'(mrt));
        chk("col_tag", 64'(col_tag_out), 64'(mct));
        if (x) valid_in[wr][wc] = 1'b0;
    endtask

    task automatic arrive(input int pct);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (!valid_in[r][c] && $urandom_range(99) < pct) begin
                    valid_in[r][c] = 1'b1;
                    data_in[r][c] = {$urandom, $urandom};
                end
    endtask

    initial begin
        int nb;
        logic [R-1:0][C-1:0] one_hot;
        model_reset();
        enable_in = 1'b1;
        ready_in = 1'b1;
        for (int r = 0; r < R; r++) begin
            row_id[r] = RW'($urandom);
            for (int c = 0; c < C; c++) begin
                col_id[r][c] = CW'($urandom);
                data_in[r][c] = {$urandom, $urandom};
                gcnt[r][c] = 0;
            end
        end
        valid_in = '1;
        #3;
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_rtag", 64'(row_tag_out), 64'd0);
        chk("rst_ctag", 64'(col_tag_out), 64'd0);
        chk_ro("rst_ready", '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_hold_valid", 64'(valid_out), 64'd0);
        chk_ro("rst_hold_ready", '0);
        reset = 1'b1;
        #1;
        one_hot = '0;
        one_hot[0][0] = 1'b1;
        chk_ro("first_grant", one_hot);

        // Full array: every PE exactly once in R*C consecutive grants.
        repeat (R * C) step();
        nb = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (gcnt[r][c] != 1) nb++;
        chk("fairness", 64'(nb), 64'd0);
        step();

        // Wrap: move the row pointer to the last row, then last-row/first-row pair.
        valid_in[10][3] = 1'b1;
        step();
        valid_in[11][13] = 1'b1;
        valid_in[0][0] = 1'b1;
        step();
        step();
        step();

        // Backpressure with many requests pending.
        arrive(50);
        step();
        ready_in = 1'b0;
        repeat (5) step();
        ready_in = 1'b1;
        repeat (20) step();

        // enable_in low: pending word drains, no grants; then resume.
        arrive(30);
        step();
        enable_in = 1'b0;
        step();
        step();
        enable_in = 1'b1;
        step();

        // Random traffic, backpressure, enable toggling and dropped requests.
        repeat (300) begin
            arrive(8);
            if ($urandom_range(9) == 0) valid_in[$urandom_range(R - 1)][$urandom_range(C - 1)] = 1'b0;
            ready_in = ($urandom_range(9) < 7);
            enable_in = ($urandom_range(9) != 0);
            step();
        end

        // Asynchronous reset between edges with a word held.
        ready_in = 1'b1;
        enable_in = 1'b1;
        valid_in[5][5] = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 64'(valid_out), 64'd0);
        chk("async_data", data_out, 64'd0);
        chk_ro("async_ready", '0);
        model_reset();
        @(posedge clk);
        #2;
        valid_in = '1;
        reset = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
